// File: rtl/pds_rx_port.sv
`default_nettype none
// ============================================================================
// Module      : pds_rx_port
// Description : Packet switch receive port. Parses header/payload/parity,
//               buffers tagged bytes in a FIFO and streams them to the core.
// Revision    : 1.0
// ============================================================================
module pds_rx_port #(
    parameter int PORTNO = 0,
    parameter int DEPTH  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [7:0]  data_in,
    output logic        suspend_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_err,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count
);

    localparam int              c_AW         = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL       = (c_AW + 1)'(DEPTH);
    localparam logic [1:0]      c_ST_IDLE    = 2'd0;
    localparam logic [1:0]      c_ST_PAYLOAD = 2'd1;
    localparam logic [1:0]      c_ST_PARITY  = 2'd2;

    if ((PORTNO < 0) || (PORTNO > 3) || (DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_param_check
        $error("pds_rx_port: illegal PORTNO or DEPTH");
    end

    logic [1:0]      r_state;
    logic [3:0]      r_rem;
    logic [7:0]      r_acc;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_occ;
    logic [10:0]     r_mem [DEPTH];
    logic [15:0]     r_pkt;
    logic [15:0]     r_err;

    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_parity_ok;
    logic        w_good_pkt;
    logic        w_err_inc;
    logic [10:0] w_wr_entry;
    logic [10:0] w_head;

    assign suspend_out = (r_occ == c_FULL);
    assign out_valid   = (r_occ != '0);
    assign w_accept    = valid_in && !suspend_out;
    assign w_pop       = out_valid && out_ready;
    assign w_parity_ok = (data_in == r_acc);

    // A zero-length header is the only accepted byte that is not stored.
    assign w_push     = w_accept && !((r_state == c_ST_IDLE) && (data_in[7:4] == 4'd0));
    assign w_good_pkt = w_accept && (r_state == c_ST_PARITY) && w_parity_ok;
    assign w_err_inc  = w_accept && (((r_state == c_ST_PARITY) && !w_parity_ok) ||
                                     ((r_state == c_ST_IDLE) && (data_in[7:4] == 4'd0)));

    always_comb begin
        w_wr_entry = {1'b0, 1'b0, 1'b0, data_in};
        case (r_state)
            c_ST_IDLE:   w_wr_entry[8]  = 1'b1;
            c_ST_PARITY: begin
                w_wr_entry[9]  = 1'b1;
                w_wr_entry[10] = !w_parity_ok;
            end
            default:     w_wr_entry = {1'b0, 1'b0, 1'b0, data_in};
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_rem   <= 4'd0;
            r_acc   <= 8'd0;
        end else if (w_accept) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (data_in[7:4] != 4'd0) begin
                        r_acc   <= data_in;
                        r_rem   <= data_in[7:4];
                        r_state <= c_ST_PAYLOAD;
                    end
                end
                c_ST_PAYLOAD: begin
                    r_acc <= r_acc ^ data_in;
                    r_rem <= r_rem - 4'd1;
                    if (r_rem == 4'd1) begin
                        r_state <= c_ST_PARITY;
                    end
                end
                c_ST_PARITY: r_state <= c_ST_IDLE;
                default:     r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pkt <= 16'd0;
            r_err <= 16'd0;
        end else begin
            if (w_good_pkt && (r_pkt != 16'hFFFF)) begin
                r_pkt <= r_pkt + 16'd1;
            end
            if (w_err_inc && (r_err != 16'hFFFF)) begin
                r_err <= r_err + 16'd1;
            end
        end
    end

    // Storage has no reset; the pointers and occupancy define what is live.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign w_head    = out_valid ? r_mem[r_rd_ptr] : 11'd0;
    assign out_data  = w_head[7:0];
    assign out_sop   = w_head[8];
    assign out_eop   = w_head[9];
    assign out_err   = w_head[10];
    assign pkt_count = r_pkt;
    assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pds_rx_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_pds_rx_port
// Description : Scoreboard bench for pds_rx_port with a byte-level port model.
// Revision    : 1.0
// ============================================================================
module tb_pds_rx_port;

    localparam int c_DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic [7:0]  data_in = 8'd0;
    logic        out_ready = 1'b0;
    logic        suspend_out;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_err;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    int n_cmp = 0;
    int n_err = 0;

    pds_rx_port #(.PORTNO(1), .DEPTH(c_DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .suspend_out(suspend_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_err    (out_err),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Port model: expected FIFO contents {err,eop,sop,data} and counters.
    logic [10:0] q[$];
    int          m_occ = 0;
    int          m_pops = 0;
    logic [1:0]  m_state = 2'd0;
    logic [3:0]  m_rem = 4'd0;
    logic [7:0]  m_acc = 8'd0;
    logic [15:0] m_pkt = 16'd0;
    logic [15:0] m_err = 16'd0;
    logic        last_eop_err = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            m_occ   <= 0;
            m_state <= 2'd0;
            m_rem   <= 4'd0;
            m_acc   <= 8'd0;
            m_pkt   <= 16'd0;
            m_err   <= 16'd0;
        end else begin
            if (m_occ != 0 && out_ready) begin
                q.delete(0);
                m_pops <= m_pops + 1;
            end
            if (valid_in && m_occ != c_DEPTH) begin
                if (m_state == 2'd0) begin
                    if (data_in[7:4] == 4'd0) begin
                        m_err <= m_err + 16'd1;
                        m_occ <= m_occ - ((m_occ != 0 && out_ready) ? 1 : 0);
                    end else begin
                        q.push_back({3'b001, data_in});
                        m_acc   <= data_in;
                        m_rem   <= data_in[7:4];
                        m_state <= 2'd1;
                        m_occ   <= m_occ + 1 - ((m_occ != 0 && out_ready) ? 1 : 0);
                    end
                end else if (m_state == 2'd1) begin
                    q.push_back({3'b000, data_in});
                    m_acc   <= m_acc ^ data_in;
                    m_rem   <= m_rem - 4'd1;
                    m_state <= (m_rem == 4'd1) ? 2'd2 : 2'd1;
                    m_occ   <= m_occ + 1 - ((m_occ != 0 && out_ready) ? 1 : 0);
                end else begin
                    q.push_back({(data_in != m_acc), 2'b10, data_in});
                    if (data_in == m_acc) m_pkt <= m_pkt + 16'd1;
                    else                  m_err <= m_err + 16'd1;
                    m_state <= 2'd0;
                    m_occ   <= m_occ + 1 - ((m_occ != 0 && out_ready) ? 1 : 0);
                end
            end else begin
                m_occ <= m_occ - ((m_occ != 0 && out_ready) ? 1 : 0);
            end
        end
    end

    always @(negedge clock) begin
        chk("suspend", {15'd0, suspend_out}, {15'd0, m_occ == c_DEPTH});
        chk("out_valid", {15'd0, out_valid}, {15'd0, m_occ != 0});
        if (m_occ != 0 && q.size() != 0)
            chk("head", {5'd0, out_err, out_eop, out_sop, out_data}, {5'd0, q[0]});
        chk("pkt_count", pkt_count, m_pkt);
        chk("err_count", err_count, m_err);
        if (out_valid && out_ready && out_eop) last_eop_err = out_err;
    end

    task automatic send_byte(input logic [7:0] b);
        valid_in = 1'b1;
        data_in  = b;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clock);
            if (!suspend_out) break;
            if (t == 2999) begin
                n_cmp++;
                n_err++;
                $error("FAIL send_timeout: observed suspended expected accept");
            end
        end
        @(posedge clock);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] len, input logic [3:0] mask, input logic [7:0] seed);
        logic [7:0] par;
        par = {len, mask};
        send_byte({len, mask});
        for (int i = 0; i < int'(len); i++) begin
            send_byte(seed + 8'(i));
            par = par ^ (seed + 8'(i));
        end
        send_byte(par);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    int base;

    initial begin
        // Reset state
        do_reset();
        @(negedge clock);
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_suspend", {15'd0, suspend_out}, 16'd0);
        chk("rst_data", {8'd0, out_data}, 16'd0);
        chk("rst_pkt", pkt_count, 16'd0);

        // Good packet, streaming consumer
        @(posedge clock); #1;
        out_ready = 1'b1;
        base = m_pops;
        send_byte(8'h32); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h32);
        repeat (4) @(posedge clock); #1;
        chk("good_pkt", pkt_count, 16'd1);
        chk("good_err", err_count, 16'd0);
        chk("good_pops", 16'(m_pops - base), 16'd5);
        chk("good_eop_err", {15'd0, last_eop_err}, 16'd0);

        // Parity error
        do_reset();
        base = m_pops;
        send_byte(8'h32); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h33);
        repeat (4) @(posedge clock); #1;
        chk("par_pkt", pkt_count, 16'd0);
        chk("par_err", err_count, 16'd1);
        chk("par_pops", 16'(m_pops - base), 16'd5);
        chk("par_eop_err", {15'd0, last_eop_err}, 16'd1);

        // Illegal header followed by a good packet
        do_reset();
        base = m_pops;
        send_byte(8'h05);
        send_pkt(4'd2, 4'h3, 8'h40);
        repeat (4) @(posedge clock); #1;
        chk("ill_err", err_count, 16'd1);
        chk("ill_pkt", pkt_count, 16'd1);
        chk("ill_pops", 16'(m_pops - base), 16'd4);

        // Back-pressure with four maximum-length packets
        do_reset();
        out_ready = 1'b0;
        base = m_pops;
        fork
            begin
                for (int p = 0; p < 4; p++) send_pkt(4'd15, 4'(p + 1), 8'(p * 32));
            end
            begin
                repeat (24) @(posedge clock); #1;
                chk("bp_full", {15'd0, suspend_out}, 16'd1);
                @(posedge clock); #1;
                out_ready = 1'b1;
                @(posedge clock); #1;
                out_ready = 1'b0;
                chk("bp_release", {15'd0, suspend_out}, 16'd0);
                @(posedge clock); #1;
                chk("bp_refill", {15'd0, suspend_out}, 16'd1);
                repeat (6) @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        repeat (20) @(posedge clock); #1;
        chk("bp_pops", 16'(m_pops - base), 16'd68);
        chk("bp_pkt", pkt_count, 16'd4);
        chk("bp_empty", {15'd0, out_valid}, 16'd0);

        // Reset in the middle of a packet
        do_reset();
        out_ready = 1'b0;
        send_byte(8'h42); send_byte(8'h01); send_byte(8'h02);
        #2 reset = 1'b1;
        #1;
        chk("mid_valid", {15'd0, out_valid}, 16'd0);
        chk("mid_fields", {5'd0, out_err, out_eop, out_sop, out_data}, 16'd0);
        chk("mid_suspend", {15'd0, suspend_out}, 16'd0);
        chk("mid_counts", pkt_count | err_count, 16'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        base = m_pops;
        send_byte(8'h10); send_byte(8'hAA); send_byte(8'hBA);
        repeat (4) @(posedge clock); #1;
        chk("post_pkt", pkt_count, 16'd1);
        chk("post_err", err_count, 16'd0);
        chk("post_pops", 16'(m_pops - base), 16'd3);
        chk("post_eop_err", {15'd0, last_eop_err}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
